// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} words with push/pop/clear and an occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2 * FETCH_XLEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;

  // NOTE: storage carries no reset; entries are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[head];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues imem requests, buffers returned words, feeds decode.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            stall_fetch_now,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_W = DEPTH[CW:0];

  fetch_state_t       state_q;
  fetch_state_t       state_d;
  logic [XLEN-1:0]    req_pc;
  logic [CW-1:0]      count;
  logic [2*XLEN-1:0]  head_entry;
  logic [CW:0]        reserved;
  logic               grant;
  logic               keep_word;
  logic               push;
  logic               pop;

  // The in-flight WAIT response already owns a slot; same-cycle pops are not credited.
  assign reserved  = {1'b0, count} + {{CW{1'b0}}, (state_q == WAIT)};
  assign imem_req  = !reset && !flush && (reserved < DEPTH_W)
                     && ((state_q == IDLE) || imem_rvalid);
  assign grant     = imem_req && imem_gnt;
  assign imem_addr = pc;
  assign stall_fetch_now = !(reset || flush || grant);
  assign keep_word = (state_q == WAIT) && imem_rvalid && !flush;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass   = keep_word && (count == '0);
  assign id_valid = (count != '0) || bypass;
  assign id_instr = (count != '0) ? head_entry[XLEN-1:0]      : (bypass ? imem_rdata : '0);
  assign id_pc    = (count != '0) ? head_entry[2*XLEN-1:XLEN] : (bypass ? req_pc     : '0);
  assign pop      = (count != '0) && id_ready && !flush;
  assign push     = keep_word && !(bypass && id_ready);
`else
  assign id_valid = (count != '0);
  assign id_instr = id_valid ? head_entry[XLEN-1:0]      : '0;
  assign id_pc    = id_valid ? head_entry[2*XLEN-1:XLEN] : '0;
  assign pop      = id_valid && id_ready && !flush;
  assign push     = keep_word;
`endif

  // NOTE: next state gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid)  state_d = grant ? WAIT : IDLE;
        else if (flush)   state_d = DROP;
      end
      DROP: if (imem_rvalid) state_d = grant ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_pc  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) req_pc <= pc;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .wdata ({req_pc, imem_rdata}),
    .rdata (head_entry),
    .count (count)
  );

  // A response with nothing outstanding is a memory-side protocol error.
  assert property (@(posedge clk) disable iff (reset) !(imem_rvalid && state_q == IDLE));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4, XLEN = 32).
module tb_fetch_queue;
  import fetch_pkg::*;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        stall_fetch_now;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .stall_fetch_now (stall_fetch_now),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h1300_0000 ^ a;
  endfunction

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (stall_fetch_now !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_fetch_now); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", id_pc); end
    @(negedge clk); reset = 1'b0; pc = 32'h40; imem_gnt = 1'b1; #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_first_req got=%b exp=1", imem_req); end
    checks++; if (stall_fetch_now !== 1'b0) begin failures++; $display("FAIL rst_first_stall got=%b exp=0", stall_fetch_now); end
    @(negedge clk); imem_gnt = 1'b0; #1;
    checks++; if (dut.state_q !== WAIT) begin failures++; $display("FAIL rst_in_wait got=%0d exp=%0d", dut.state_q, WAIT); end
    checks++; if (stall_fetch_now !== 1'b1) begin failures++; $display("FAIL rst_wait_stall got=%b exp=1", stall_fetch_now); end
    #1 reset = 1'b1; #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_mid_req got=%b exp=0", imem_req); end
    checks++; if (stall_fetch_now !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%b exp=0", stall_fetch_now); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", id_valid); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL rst_mid_state got=%0d exp=%0d", dut.state_q, IDLE); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL rst_rel_state got=%0d exp=%0d", dut.state_q, IDLE); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_rel_req got=%b exp=1", imem_req); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pc          = (k <= 3) ? 32'(k * 4) : 32'hC;
      imem_gnt    = (k <= 2);
      imem_rvalid = (k >= 1) && (k <= 3);
      imem_rdata  = word_of(32'((k - 1) * 4));
      id_ready    = 1'b1;
      #1;
      if (k <= 2) begin
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL str_req k=%0d got=%b exp=1", k, imem_req); end
        checks++; if (stall_fetch_now !== 1'b0) begin failures++; $display("FAIL str_stall k=%0d got=%b exp=0", k, stall_fetch_now); end
      end
      checks++;
      if (id_valid !== ((k >= LAT) && (k < LAT + 3))) begin
        failures++; $display("FAIL str_valid k=%0d got=%b exp=%b", k, id_valid, (k >= LAT) && (k < LAT + 3));
      end
      if ((k >= LAT) && (k < LAT + 3)) begin
        checks++; if (id_pc !== 32'((k - LAT) * 4)) begin failures++; $display("FAIL str_pc k=%0d got=%h exp=%h", k, id_pc, 32'((k - LAT) * 4)); end
        checks++; if (id_instr !== word_of(32'((k - LAT) * 4))) begin failures++; $display("FAIL str_instr k=%0d got=%h", k, id_instr); end
      end
    end
    checks++; if (stall_fetch_now !== 1'b1) begin failures++; $display("FAIL str_idle_stall got=%b exp=1", stall_fetch_now); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      id_ready    = 1'b0;
      pc          = (k <= 4) ? 32'(k * 4) : 32'h10;
      imem_gnt    = 1'b1;
      imem_rvalid = (k >= 1) && (k <= 4);
      imem_rdata  = word_of(32'((k - 1) * 4));
      #1;
      if (k <= 3) begin
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL bp_fill_req k=%0d got=%b exp=1", k, imem_req); end
      end else begin
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_full_req k=%0d got=%b exp=0", k, imem_req); end
        checks++; if (stall_fetch_now !== 1'b1) begin failures++; $display("FAIL bp_full_stall k=%0d got=%b exp=1", k, stall_fetch_now); end
      end
    end
    checks++; if (dut.count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", dut.count); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      id_ready    = (k <= 4);
      pc          = (k <= 1) ? 32'h10 : 32'h14;
      imem_gnt    = (k == 1);
      imem_rvalid = (k == 2);
      imem_rdata  = word_of(32'h10);
      #1;
      if (k <= 4) begin
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_valid k=%0d got=%b exp=1", k, id_valid); end
        checks++; if (id_pc !== 32'(k * 4)) begin failures++; $display("FAIL bp_drain_pc k=%0d got=%h exp=%h", k, id_pc, 32'(k * 4)); end
        checks++; if (id_instr !== word_of(32'(k * 4))) begin failures++; $display("FAIL bp_drain_instr k=%0d got=%h", k, id_instr); end
      end else begin
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL bp_empty_valid got=%b exp=0", id_valid); end
      end
      if (k == 0) begin
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_nocredit_req got=%b exp=0", imem_req); end
      end
      if (k == 1) begin
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL bp_resume_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL bp_resume_addr got=%h exp=10", imem_addr); end
        checks++; if (stall_fetch_now !== 1'b0) begin failures++; $display("FAIL bp_resume_stall got=%b exp=0", stall_fetch_now); end
      end
    end
  endtask

  task automatic test_flush_wait();
    @(negedge clk); id_ready = 1'b1; pc = 32'h20; imem_gnt = 1'b1; imem_rvalid = 1'b0; #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL fw_req got=%b exp=1", imem_req); end
    @(negedge clk); imem_gnt = 1'b0; flush = 1'b1; #1;
    checks++; if (stall_fetch_now !== 1'b0) begin failures++; $display("FAIL fw_flush_stall got=%b exp=0", stall_fetch_now); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL fw_flush_req got=%b exp=0", imem_req); end
    @(negedge clk); flush = 1'b0; pc = 32'h100; #1;
    checks++; if (dut.state_q !== DROP) begin failures++; $display("FAIL fw_drop_state got=%0d exp=%0d", dut.state_q, DROP); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL fw_drop_req got=%b exp=0", imem_req); end
    @(negedge clk); imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF; imem_gnt = 1'b1; #1;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL fw_late_valid got=%b exp=0 instr=%h", id_valid, id_instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL fw_redirect req=%b addr=%h exp=1/100", imem_req, imem_addr); end
    checks++; if (stall_fetch_now !== 1'b0) begin failures++; $display("FAIL fw_redirect_stall got=%b exp=0", stall_fetch_now); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      imem_rvalid = (k == 1);
      imem_rdata  = word_of(32'h100);
      imem_gnt    = 1'b0;
      #1;
      checks++;
      if (id_valid !== (k == LAT)) begin failures++; $display("FAIL fw_valid k=%0d got=%b exp=%b", k, id_valid, k == LAT); end
      if (k == LAT) begin
        checks++; if (id_pc !== 32'h100 || id_instr !== word_of(32'h100)) begin
          failures++; $display("FAIL fw_word pc=%h instr=%h exp=100/%h", id_pc, id_instr, word_of(32'h100));
        end
      end
    end
  endtask

  task automatic test_flush_full();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      id_ready    = 1'b0;
      imem_gnt    = 1'b1;
      pc          = 32'(k * 4);
      imem_rvalid = (k >= 1);
      imem_rdata  = word_of(32'((k - 1) * 4));
      #1;
    end
    @(negedge clk);
    flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = word_of(32'hC); id_ready = 1'b1; pc = 32'h10;
    #1;
    checks++; if (dut.count !== 3'd3) begin failures++; $display("FAIL ff_pre_count got=%0d exp=3", dut.count); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ff_req got=%b exp=0", imem_req); end
    checks++; if (stall_fetch_now !== 1'b0) begin failures++; $display("FAIL ff_stall got=%b exp=0", stall_fetch_now); end
    @(negedge clk);
    flush = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0;
    #1;
    checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL ff_count got=%0d exp=0", dut.count); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL ff_valid got=%b exp=0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL ff_instr got=%h exp=0", id_instr); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL ff_state got=%0d exp=%0d", dut.state_q, IDLE); end
  endtask

`ifdef FETCH_BYPASS_EN
  task automatic test_bypass();
    @(negedge clk); pc = 32'h200; imem_gnt = 1'b1; imem_rvalid = 1'b0; id_ready = 1'b1; #1;
    @(negedge clk); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; #1;
    checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL byp_valid got=%b exp=1", id_valid); end
    checks++; if (id_instr !== 32'h0050_0093) begin failures++; $display("FAIL byp_instr got=%h exp=00500093", id_instr); end
    checks++; if (id_pc !== 32'h200) begin failures++; $display("FAIL byp_pc got=%h exp=200", id_pc); end
    @(negedge clk); imem_rvalid = 1'b0; #1;
    checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL byp_count got=%0d exp=0", dut.count); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL byp_after_valid got=%b exp=0", id_valid); end
  endtask
`endif

  initial begin
    reset = 1'b1; pc = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    flush = 1'b0; id_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_wait();
    test_flush_full();
`ifdef FETCH_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register in each core.
- Samples `pc`, issues requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned words with their PCs in a small FIFO.
- Presents buffered words to decode over a valid/ready interface.
- Drives `stall_fetch_now` back to the PC register, so the PC advances only when a fetch request is accepted.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- XLEN, 32, width of address, instruction and PC.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pc  in  XLEN  current PC-register value.
- stall_fetch_now  out  1  high = PC register holds at next edge.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; always equals `pc`.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response word valid; earliest 1 cycle after gnt.
- imem_rdata  in  XLEN  response word.
- flush  in  1  branch/jump redirect; discard all fetched state.
- id_valid  out  1  decode entry valid.
- id_ready  in  1  decode accepts entry.
- id_instr  out  XLEN  instruction to decode.
- id_pc  out  XLEN  PC of `id_instr`.

Behaviour:
- Reset:
  - state = IDLE, count = 0, head/tail = 0, req_pc = 0.
  - imem_req = 0, id_valid = 0, id_instr = 0, id_pc = 0.
  - stall_fetch_now forced 0 while reset is high, so the PC register is free to reset.
- FSM, at most one outstanding request:
  - IDLE: no request in flight.
  - WAIT: one request in flight; its response will be kept.
  - DROP: one request in flight; its response will be discarded.
- Transitions:
  - IDLE -> WAIT on imem_req && imem_gnt.
  - WAIT/DROP on imem_rvalid: -> WAIT if a new request is granted in the same cycle, else -> IDLE.
  - WAIT -> DROP on flush without rvalid.
  - flush with rvalid in WAIT: the word is discarded, state -> IDLE.
- Issue rule:
  - reserved = count + (state == WAIT).
  - imem_req = !flush && reserved < DEPTH && (state == IDLE || imem_rvalid).
  - The pop in the same cycle is deliberately not credited, so there is no id_ready -> imem_req path.
- Grant: latch req_pc <= pc. stall_fetch_now = !(imem_req && imem_gnt), except:
  - forced 0 during flush, so the redirect target loads;
  - forced 0 during reset.
- Push: imem_rvalid in WAIT (no flush) writes {req_pc, imem_rdata} at tail.
  - Space is guaranteed by the issue rule.
  - rvalid in IDLE is a protocol error: ignored, and asserted against in simulation.
- Pop:
  - id_valid = count != 0.
  - id_instr/id_pc = head entry.
  - Pop on id_valid && id_ready.
  - Push and pop in the same cycle leave count unchanged.
- Flush: count, head and tail cleared next edge; a pop in the same cycle is ignored.
- Latency: grant -> earliest id_valid is 2 cycles (rvalid + 1).
- Sustained rate: 1 instruction/cycle if memory returns rvalid the cycle after gnt and decode is always ready.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When count == 0 and WAIT && imem_rvalid && !flush, id_valid = 1 and id_instr/id_pc come straight from imem_rdata/req_pc.
  - If id_ready is also high, the word is consumed without being pushed.
  - Grant -> id_valid latency drops to 1 cycle.
- Undefined:
  - All words pass through the queue.
  - id_valid is driven from registered state only.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, WAIT, DROP};
  - fetch_entry_t struct {pc, instr};
  - constant FETCH_NOP = 32'h0000_0013.
- Sub-module fetch_fifo: storage plus head/tail/count, with push/pop/clear ports.
- The FSM, issue logic and bypass stay in fetch_queue.

Test Plan:
- Reset mid-request (WAIT, pc = 0x40): assert reset -> imem_req = 0, id_valid = 0, stall_fetch_now = 0 immediately; IDLE after release.
- Streaming, 1-cycle memory, id_ready = 1, pc 0x0, 0x4, 0x8 -> id_pc 0x0, 0x4, 0x8 on consecutive cycles; stall_fetch_now low every grant cycle.
- Backpressure, id_ready = 0, DEPTH = 4:
  - after 4 words, imem_req = 0 and stall_fetch_now = 1;
  - raise id_ready -> drain in order 0x0..0xC, fetch resumes at 0x10.
- Flush while in WAIT (req pc 0x20) -> state DROP; the late rvalid word 0xDEADBEEF never appears on id_*; next fetch uses the redirected pc 0x100.
- Flush with rvalid, pop and full queue all in the same cycle -> count = 0 next cycle, id_valid = 0, no entry delivered.
- With FETCH_BYPASS_EN, empty queue, rvalid with rdata 0x00500093 and id_ready = 1 -> id_valid in the same cycle with that word; count stays 0.
